// File: rtl/fxp_pkg.sv
// -----------------------------------------------------------------------------
// fxp_pkg
// Shared fixed-point helpers for the float-to-fixed processing chain.
//   acc_width(wii, block_len, wof) : lossless accumulator width for a block sum
//   max_raw(w) / min_raw(w)        : largest / smallest signed raw value of a
//                                    w-bit two's-complement word, returned in
//                                    64 bits (callers slice the low w bits)
// -----------------------------------------------------------------------------
package fxp_pkg;

  // One extra bit beyond the block growth keeps the sign unambiguous.
  function automatic int acc_width(input int wii, input int block_len, input int wof);
    return wii + $clog2(block_len) + wof + 1;
  endfunction

  function automatic logic [63:0] max_raw(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] min_raw(input int w);
    return ~max_raw(w);
  endfunction

endpackage

// File: rtl/fxp_narrow.sv
// -----------------------------------------------------------------------------
// fxp_narrow
// Combinational narrowing of a WA-bit signed sum to a WO-bit signed word.
// Build option: FXP_ACC_SATURATE_EN -- when defined, out-of-range sums clamp to
// the most positive / most negative WO-bit value; otherwise the low WO bits are
// passed through (wrap). The range flag is produced identically in both builds.
// Ports:
//   i_sum        WA-bit signed input sum
//   o_data       WO-bit narrowed result
//   o_range_ovf  1 when i_sum does not fit in WO signed bits
// -----------------------------------------------------------------------------
module fxp_narrow
  import fxp_pkg::*;
#(
  parameter int WA = 23,
  parameter int WO = 20
) (
  input  logic [WA-1:0] i_sum,
  output logic [WO-1:0] o_data,
  output logic          o_range_ovf
);

  if (WO > 64) begin : g_chk_wo
    $error("fxp_narrow: WO must not exceed 64");
  end

  if (WA <= WO) begin : g_widen
    // Target is at least as wide: plain sign extension, never out of range.
    assign o_data      = {{(WO-WA){i_sum[WA-1]}}, i_sum};
    assign o_range_ovf = 1'b0;
  end else begin : g_narrow
    localparam logic [63:0] MAX_RAW = max_raw(WO);
    localparam logic [63:0] MIN_RAW = min_raw(WO);

    // The value fits iff every bit from the target sign bit upward agrees.
    logic [WA-WO:0] top_bits;
    assign top_bits    = i_sum[WA-1:WO-1];
    assign o_range_ovf = !((&top_bits) || !(|top_bits));

`ifdef FXP_ACC_SATURATE_EN
    always_comb begin
      o_data = i_sum[WO-1:0];
      if (o_range_ovf) begin
        o_data = i_sum[WA-1] ? MIN_RAW[WO-1:0] : MAX_RAW[WO-1:0];
      end
    end
`else
    assign o_data = i_sum[WO-1:0];
`endif
  end

endmodule

// File: rtl/pipe_fixed_block_accumulator.sv
// -----------------------------------------------------------------------------
// pipe_fixed_block_accumulator
// Sums every BLOCK_LEN accepted signed fixed-point samples in a lossless
// accumulator and emits one narrowed result per block through a single-entry
// output register. Accumulation of the next block continues while a result
// waits; only the final sample of a block stalls on an unconsumed result.
// Build option: FXP_ACC_SATURATE_EN (saturate instead of wrap on narrowing,
// selected inside fxp_narrow).
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   i_valid/i_ready      input sample handshake
//   i_data, i_ovf        signed sample (WII.WIF) and its upstream overflow flag
//   o_valid/o_ready      output sum handshake
//   o_data, o_overflow   signed block sum (WOI.WOF) and its invalid flag
// -----------------------------------------------------------------------------
module pipe_fixed_block_accumulator
  import fxp_pkg::*;
#(
  parameter int WII       = 10,
  parameter int WIF       = 10,
  parameter int WOI       = 16,
  parameter int WOF       = 10,
  parameter int BLOCK_LEN = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [WII+WIF-1:0]   i_data,
  input  logic                 i_ovf,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [WOI+WOF-1:0]   o_data,
  output logic                 o_overflow
);

  localparam int WI    = WII + WIF;
  localparam int WO    = WOI + WOF;
  localparam int WA    = acc_width(WII, BLOCK_LEN, WOF);
  localparam int SHIFT = WOF - WIF;
  localparam int CW    = $clog2(BLOCK_LEN);
  localparam logic [CW-1:0] LAST = CW'(BLOCK_LEN - 1);

  if (WOF < WIF) begin : g_chk_wof
    $error("pipe_fixed_block_accumulator: WOF must be >= WIF");
  end
  if (BLOCK_LEN < 2) begin : g_chk_len
    $error("pipe_fixed_block_accumulator: BLOCK_LEN must be >= 2");
  end

  logic [WA-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_acc_q, ovf_acc_d;
  logic          o_valid_q, o_valid_d;
  logic [WO-1:0] o_data_q, o_data_d;
  logic          o_ovf_q, o_ovf_d;

  logic signed [WA-1:0] samp_ext;
  logic [WA-1:0]        sum;
  logic [WO-1:0]        narrow_data;
  logic                 range_ovf;
  logic                 last, accept, pop;

  // ---- input alignment and accumulation (combinational) ----
  assign samp_ext = WA'($signed(i_data)) <<< SHIFT;
  assign sum      = acc_q + samp_ext;

  assign last    = (cnt_q == LAST);
  assign i_ready = !(o_valid_q && !o_ready && last);
  assign accept  = i_valid && i_ready;
  assign pop     = o_valid_q && o_ready;

  fxp_narrow #(
    .WA (WA),
    .WO (WO)
  ) u_narrow (
    .i_sum       (sum),
    .o_data      (narrow_data),
    .o_range_ovf (range_ovf)
  );

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_acc_d = ovf_acc_q;
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_ovf_d   = o_ovf_q;

    if (pop) begin
      o_valid_d = 1'b0;
    end

    if (accept) begin
      if (last) begin
        // Block closes: publish result (overrides a same-cycle pop) and restart.
        o_data_d  = narrow_data;
        o_ovf_d   = ovf_acc_q | i_ovf | range_ovf;
        o_valid_d = 1'b1;
        acc_d     = '0;
        cnt_d     = '0;
        ovf_acc_d = 1'b0;
      end else begin
        acc_d     = sum;
        cnt_d     = cnt_q + 1'b1;
        ovf_acc_d = ovf_acc_q | i_ovf;
      end
    end
  end

  // ---- state / output register stage ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_ovf_q   <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_acc_q <= ovf_acc_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_ovf_q   <= o_ovf_d;
    end
  end

  assign o_valid    = o_valid_q;
  assign o_data     = o_data_q;
  assign o_overflow = o_ovf_q;

endmodule

// File: tb/tb_pipe_fixed_block_accumulator.sv
// -----------------------------------------------------------------------------
// tb_pipe_fixed_block_accumulator
// Two instances with BLOCK_LEN=4: "a" uses the default output format (26 bits),
// "s" uses WOI=10 (20 bits) to exercise narrowing overflow. Expected values are
// hand-computed raw sums (WIF == WOF, so raw output equals raw input sum).
// -----------------------------------------------------------------------------
module tb_pipe_fixed_block_accumulator;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        a_iv, a_ir, a_io, a_ov, a_or, a_oo;
  logic [19:0] a_id;
  logic [25:0] a_od;
  logic        s_iv, s_ir, s_io, s_ov, s_or, s_oo;
  logic [19:0] s_id;
  logic [19:0] s_od;

  pipe_fixed_block_accumulator #(.BLOCK_LEN(4)) dut_a (
    .clk(clk), .rstn(rstn), .i_valid(a_iv), .i_ready(a_ir), .i_data(a_id),
    .i_ovf(a_io), .o_valid(a_ov), .o_ready(a_or), .o_data(a_od), .o_overflow(a_oo)
  );

  pipe_fixed_block_accumulator #(.WOI(10), .BLOCK_LEN(4)) dut_s (
    .clk(clk), .rstn(rstn), .i_valid(s_iv), .i_ready(s_ir), .i_data(s_id),
    .i_ovf(s_io), .o_valid(s_ov), .o_ready(s_or), .o_data(s_od), .o_overflow(s_oo)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          sel;      // 0: dut_a, 1: dut_s
    int          d [4];
    logic [3:0]  ovf;
    logic [25:0] exp_d;
    logic        exp_o;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [19:0] s20(input int v);
    return v[19:0];
  endfunction

  function automatic logic [25:0] s26(input int v);
    return v[25:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic addv(input bit sel, input int d0, input int d1, input int d2, input int d3,
                      input logic [3:0] ovf, input int exp_d, input logic exp_o);
    vec_t v;
    v.sel = sel; v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    v.ovf = ovf; v.exp_d = s26(exp_d); v.exp_o = exp_o;
    vecs.push_back(v);
  endtask

  // Present one sample, wait (bounded) for acceptance, leave inputs idle after.
  task automatic push(input bit sel, input logic [19:0] d, input logic ovf);
    int n = 0;
    if (sel) begin s_iv = 1'b1; s_id = d; s_io = ovf; end
    else     begin a_iv = 1'b1; a_id = d; a_io = ovf; end
    #1;
    while (!(sel ? s_ir : a_ir)) begin
      @(posedge clk); #1;
      n++;
      if (n > 20) begin
        chk("push_timeout", 64'(n), 64'd0);
        break;
      end
    end
    @(posedge clk); #1;
    a_iv = 1'b0; s_iv = 1'b0; a_io = 1'b0; s_io = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    a_iv = 0; a_id = '0; a_io = 0; a_or = 1;
    s_iv = 0; s_id = '0; s_io = 0; s_or = 1;

    // ---- vector table ----
    addv(0, 1536, 2304, -768, 3072, 4'b0000, 6144, 1'b0);
    addv(0, 0, 0, 0, 0, 4'b0000, 0, 1'b0);
    addv(0, 524287, 524287, 524287, 524287, 4'b0000, 2097148, 1'b0);
    addv(0, -524288, -524288, -524288, -524288, 4'b0000, -2097152, 1'b0);
    addv(0, 100, -100, 7, -3, 4'b0010, 4, 1'b1);     // i_ovf on sample 2
    addv(0, 10, 20, 30, 40, 4'b0000, 100, 1'b0);     // sticky flag cleared
    addv(0, 1, -1, 1, -2, 4'b1000, -1, 1'b1);        // i_ovf on final sample
    addv(1, 1024, 1024, 1024, 1024, 4'b0000, 4096, 1'b0);
`ifdef FXP_ACC_SATURATE_EN
    addv(1, 523264, 523264, 523264, 523264, 4'b0000, 32'h7FFFF, 1'b1);
    addv(1, -524288, -524288, -524288, -524288, 4'b0000, 32'h80000, 1'b1);
`else
    addv(1, 523264, 523264, 523264, 523264, 4'b0000, 32'hFF000, 1'b1);
    addv(1, -524288, -524288, -524288, -524288, 4'b0000, 0, 1'b1);
`endif

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o_valid", 64'(a_ov), 64'd0);
    chk("rst_o_data", 64'(a_od), 64'd0);
    chk("rst_o_overflow", 64'(a_oo), 64'd0);
    chk("rst_i_ready", 64'(a_ir), 64'd1);
    rstn = 1'b1;
    @(posedge clk); #1;

    // ---- table-driven blocks, o_ready held high ----
    foreach (vecs[i]) begin
      for (int k = 0; k < 4; k++) push(vecs[i].sel, s20(vecs[i].d[k]), vecs[i].ovf[k]);
      if (vecs[i].sel) begin
        chk($sformatf("v%0d_valid", i), 64'(s_ov), 64'd1);
        chk($sformatf("v%0d_data", i), 64'(s_od), 64'(vecs[i].exp_d[19:0]));
        chk($sformatf("v%0d_ovf", i), 64'(s_oo), 64'(vecs[i].exp_o));
      end else begin
        chk($sformatf("v%0d_valid", i), 64'(a_ov), 64'd1);
        chk($sformatf("v%0d_data", i), 64'(a_od), 64'(vecs[i].exp_d));
        chk($sformatf("v%0d_ovf", i), 64'(a_oo), 64'(vecs[i].exp_o));
      end
    end
    @(posedge clk); #1;
    chk("pop_clears_valid", 64'(a_ov), 64'd0);

    // ---- backpressure through two blocks ----
    a_or = 1'b0;
    for (int k = 1; k <= 4; k++) push(0, s20(k), 1'b0);
    chk("bp_first_valid", 64'(a_ov), 64'd1);
    chk("bp_first_data", 64'(a_od), 64'd10);
    for (int k = 5; k <= 7; k++) begin
      #0 chk($sformatf("bp_ready_cnt%0d", k - 5), 64'(a_ir), 64'd1);
      push(0, s20(k), 1'b0);
    end
    a_iv = 1'b1; a_id = s20(8); a_io = 1'b0;
    #1;
    chk("bp_stall_ready", 64'(a_ir), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_stall_ready_held", 64'(a_ir), 64'd0);
    chk("bp_hold_valid", 64'(a_ov), 64'd1);
    chk("bp_hold_data", 64'(a_od), 64'd10);
    a_or = 1'b1;
    #1;
    chk("bp_release_ready", 64'(a_ir), 64'd1);
    @(posedge clk); #1;
    a_iv = 1'b0; a_or = 1'b0;
    chk("bp_pop_and_load_valid", 64'(a_ov), 64'd1);
    chk("bp_second_data", 64'(a_od), 64'd26);
    chk("bp_second_ovf", 64'(a_oo), 64'd0);
    a_or = 1'b1;
    @(posedge clk); #1;
    chk("bp_final_pop", 64'(a_ov), 64'd0);

    // ---- reset mid-block ----
    push(0, s20(1000), 1'b1);
    push(0, s20(2000), 1'b0);
    rstn = 1'b0;
    #1;
    chk("mrst_valid", 64'(a_ov), 64'd0);
    chk("mrst_data", 64'(a_od), 64'd0);
    chk("mrst_ovf", 64'(a_oo), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int k = 1; k <= 4; k++) push(0, s20(k), 1'b0);
    chk("mrst_after_valid", 64'(a_ov), 64'd1);
    chk("mrst_after_data", 64'(a_od), 64'd10);
    chk("mrst_after_ovf", 64'(a_oo), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog in case a handshake never completes.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
